// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single RAM port and a peripheral manager.
// Fixed or round-robin priority, configurable RAM read latency, registered outputs.
module ram_arbiter #(
    parameter int LATENCY    = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_in,
    output logic        ram_write_enable,
    input  logic [31:0] ram_data_out,
    output logic        periph_we,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] LAST_CNT = 3'(LATENCY - 1);

    state_t      state;
    logic        last_grant;
    logic        cur_we;
    logic        cur_ram;
    logic [2:0]  cnt;

    logic        pick;
    logic        sel_we;
    logic        sel_ram;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        access_done;

    // Winner selection; only consumed in IDLE.
    always_comb begin
        if (m0_req && m1_req) begin
            pick = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else begin
            pick = ~m0_req;
        end
        sel_we      = pick ? m1_we    : m0_we;
        sel_addr    = pick ? m1_addr  : m0_addr;
        sel_wdata   = pick ? m1_wdata : m0_wdata;
        sel_ram     = (sel_addr[31:29] == 3'b000);
        access_done = cur_we || !cur_ram || (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            grant_id         <= 1'b0;
            cur_we           <= 1'b0;
            cur_ram          <= 1'b0;
            cnt              <= 3'd0;
            busy             <= 1'b0;
            m0_ack           <= 1'b0;
            m1_ack           <= 1'b0;
            m0_rdata         <= 32'd0;
            m1_rdata         <= 32'd0;
            ram_address      <= 32'd0;
            ram_data_in      <= 32'd0;
            ram_write_enable <= 1'b0;
            periph_we        <= 1'b0;
        end else begin
            // NOTE: strobes and acks default low each cycle so they can only ever be one-cycle pulses.
            ram_write_enable <= 1'b0;
            periph_we        <= 1'b0;
            m0_ack           <= 1'b0;
            m1_ack           <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state            <= ACCESS;
                        busy             <= 1'b1;
                        grant_id         <= pick;
                        last_grant       <= pick;
                        cnt              <= 3'd0;
                        cur_we           <= sel_we;
                        cur_ram          <= sel_ram;
                        ram_address      <= sel_addr;
                        ram_data_in      <= sel_wdata;
                        ram_write_enable <= sel_we && sel_ram;
                        periph_we        <= sel_we && !sel_ram;
                    end
                end
                ACCESS: begin
                    if (access_done) begin
                        state <= RESP;
                        if (grant_id) begin
                            m1_ack <= 1'b1;
                            if (!cur_we) m1_rdata <= cur_ram ? ram_data_out : 32'd0;
                        end else begin
                            m0_ack <= 1'b1;
                            if (!cur_we) m0_rdata <= cur_ram ? ram_data_out : 32'd0;
                        end
                    end else if (cnt != 3'd7) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP: begin
                    // Leaving RESP always passes through IDLE, so the bus is parked at zero here.
                    state       <= IDLE;
                    busy        <= 1'b0;
                    ram_address <= 32'd0;
                    ram_data_in <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
